// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory access controller (req/ack backing bus, stall, timeout); optional macro DMEM_POSTED_WRITE_EN
module dmem_ctrl #(
  parameter int          ADDR_W   = 16,
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_MEM_mem_DmemAddr,
  input  logic [31:0]       i_MEM_mem_DmemDataW,
  input  logic              i_MEM_mem_MemRead,
  input  logic              i_MEM_mem_MemWrite,
  output logic [31:0]       o_MEM_mem_DmemDataR,
  output logic              o_stall,
  output logic              o_AlignErr,
  output logic              o_BusErr,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

`ifdef DMEM_POSTED_WRITE_EN
  localparam logic POSTED_EN = 1'b1;
`else
  localparam logic POSTED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              posted_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       data_q;
  logic [31:0]       hold_q;
  logic              acc, mis, capture, timeout_hit;
  logic              unused_addr_hi;

  assign acc = i_MEM_mem_MemRead | i_MEM_mem_MemWrite;
  assign mis = acc & (i_MEM_mem_DmemAddr[1:0] != 2'b00);

  // Upper byte-address bits lie beyond the backing bus and are intentionally dropped.
  assign unused_addr_hi = ^i_MEM_mem_DmemAddr[31:ADDR_W+2];

  assign o_bus_addr  = addr_q;
  assign o_bus_we    = we_q;
  assign o_bus_wdata = wdata_q;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, stall/handshake outputs and the load-data mux.
  always_comb begin
    state_d             = state_q;
    capture             = 1'b0;
    timeout_hit         = 1'b0;
    o_stall             = 1'b0;
    o_AlignErr          = 1'b0;
    o_BusErr            = 1'b0;
    o_bus_req           = 1'b0;
    o_MEM_mem_DmemDataR = hold_q;
    case (state_q)
      IDLE: begin
        if (acc && !mis) begin
          capture = 1'b1;
          state_d = BUSY;
          // A posted store lets the pipeline run on; everything else blocks.
          o_stall = !(POSTED_EN && i_MEM_mem_MemWrite);
        end else if (mis) begin
          o_AlignErr          = 1'b1;
          o_MEM_mem_DmemDataR = ERR_DATA;
        end
      end
      BUSY: begin
        o_bus_req = 1'b1;
        // During a posted store only a newly presented access must wait.
        o_stall   = posted_q ? acc : 1'b1;
        if (i_bus_ack) begin
          state_d = posted_q ? IDLE : DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          timeout_hit = 1'b1;
          o_BusErr    = 1'b1;
          state_d     = posted_q ? IDLE : DONE;
        end
      end
      DONE: begin
        o_MEM_mem_DmemDataR = data_q;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, BUSY cycle counter, read-data register and held load output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      posted_q <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      hold_q   <= '0;
    end else begin
      hold_q <= o_MEM_mem_DmemDataR;
      if (capture) begin
        addr_q   <= i_MEM_mem_DmemAddr[ADDR_W+1:2];
        wdata_q  <= i_MEM_mem_DmemDataW;
        we_q     <= i_MEM_mem_MemWrite;
        posted_q <= POSTED_EN & i_MEM_mem_MemWrite;
      end
      if ((state_q == BUSY) && (state_d == BUSY)) cnt_q <= cnt_q + CNT_W'(1);
      else                                        cnt_q <= '0;
      if (state_q == BUSY) begin
        if (i_bus_ack) begin
          if (!we_q) data_q <= i_bus_rdata;
        end else if (timeout_hit) begin
          data_q <= ERR_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl with a transaction-level expectation model
module tb_dmem_ctrl;

  localparam int          ADDR_W  = 16;
  localparam int          TIMEOUT = 4;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       addr, wdata, rdata, dout;
  logic              rd, wr, ack;
  logic              stall, align_err, bus_err, bus_req, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;

  dmem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .i_MEM_mem_DmemAddr(addr), .i_MEM_mem_DmemDataW(wdata),
    .i_MEM_mem_MemRead(rd), .i_MEM_mem_MemWrite(wr),
    .o_MEM_mem_DmemDataR(dout), .o_stall(stall),
    .o_AlignErr(align_err), .o_BusErr(bus_err),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .i_bus_ack(ack), .i_bus_rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              stall, req, we, align, berr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata, dout;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0, n_tot = 0;
  int          stall_cnt = 0, req_cnt = 0, berr_cnt = 0;
  logic [31:0] m_data = 32'h0, m_dout = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic exp_t mk(input logic st, rq, we, al, be,
                              input logic [ADDR_W-1:0] ad, input logic [31:0] wd, dt);
    exp_t e;
    e.stall = st; e.req = rq; e.we = we; e.align = al; e.berr = be;
    e.addr = ad; e.wdata = wd; e.dout = dt;
    return e;
  endfunction

  // Per-cycle compare against the expectation queue, sampled mid-cycle.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (stall)   stall_cnt++;
    if (bus_req) req_cnt++;
    if (bus_err) berr_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("bus_req", 32'(bus_req), 32'(e.req));
      chk("align_err", 32'(align_err), 32'(e.align));
      chk("bus_err", 32'(bus_err), 32'(e.berr));
      chk("dmem_data_r", dout, e.dout);
      if (e.req) begin
        chk("bus_we", 32'(bus_we), 32'(e.we));
        chk("bus_addr", 32'(bus_addr), 32'(e.addr));
        chk("bus_wdata", bus_wdata, e.wdata);
      end
    end
  end

  task automatic cyc(input logic r, w, input logic [31:0] a, wd, input logic k,
                     input logic [31:0] rdt, input exp_t e);
    @(posedge clk);
    #1;
    rd = r; wr = w; addr = a; wdata = wd; ack = k; rdata = rdt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 32'h3, 32'h0, 1'b0, 32'h0, mk(0, 0, 0, 0, 0, '0, '0, m_dout));
  endtask

  // One MEM-stage access; ack_at = BUSY cycle carrying ack (0 or > TIMEOUT: never acked).
  task automatic do_access(input logic r, w, input logic [31:0] a, wd, input int ack_at,
                           input logic [31:0] rdt);
    logic [ADDR_W-1:0] wa;
    logic              tmo;
    int                len;
    wa = a[ADDR_W+1:2];
    if (a[1:0] != 2'b00) begin
      m_dout = ERR;
      cyc(r, w, a, wd, 1'b0, 32'h0, mk(0, 0, 0, 1, 0, '0, '0, ERR));
      return;
    end
    tmo = !(ack_at >= 1 && ack_at <= TIMEOUT);
    len = tmo ? TIMEOUT : ack_at;
    cyc(r, w, a, wd, 1'b0, 32'h0, mk(1, 0, 0, 0, 0, '0, '0, m_dout));
    for (int j = 1; j <= len; j++)
      cyc(r, w, a, wd, (j == ack_at), (j == ack_at) ? rdt : 32'h5A5A_0000 + 32'(j),
          mk(1, 1, w, 0, tmo && (j == len), wa, wd, m_dout));
    if (tmo)     m_data = ERR;
    else if (!w) m_data = rdt;
    m_dout = m_data;
    // Stray ack with junk data while DONE must be ignored; the access is still presented.
    cyc(r, w, a, wd, 1'b1, 32'hBAD0_0BAD, mk(0, 0, 0, 0, 0, '0, '0, m_dout));
  endtask

  initial begin : stim
    int s0, r0, b0;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; ack = 1'b0;
    addr = 32'h0; wdata = 32'h0; rdata = 32'h0;
    repeat (2) cyc(0, 0, 32'h0, 32'h0, 0, 32'h0, mk(0, 0, 0, 0, 0, '0, '0, 32'h0));
    rst = 1'b0;
    idle(1);

    s0 = stall_cnt; r0 = req_cnt;
    do_access(1, 0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678);
    idle(1);
    chk("t1_stall_cycles", 32'(stall_cnt - s0), 32'd4);
    chk("t1_req_cycles", 32'(req_cnt - r0), 32'd3);
    chk("t1_data", dout, 32'h1234_5678);

    s0 = stall_cnt; r0 = req_cnt;
    do_access(0, 1, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'h0);
    idle(1);
    chk("t2_stall_cycles", 32'(stall_cnt - s0), 32'd2);
    chk("t2_req_cycles", 32'(req_cnt - r0), 32'd1);

    s0 = stall_cnt; r0 = req_cnt;
    do_access(1, 0, 32'h0000_0013, 32'h0, 1, 32'h0);
    idle(2);
    chk("t3_stall_cycles", 32'(stall_cnt - s0), 32'd0);
    chk("t3_req_cycles", 32'(req_cnt - r0), 32'd0);
    chk("t3_err_data_held", dout, 32'hDEAD_BEEF);

    b0 = berr_cnt;
    do_access(1, 0, 32'h0000_0100, 32'h0, TIMEOUT, 32'h7777_0001);
    idle(1);
    chk("limit_ack_no_err", 32'(berr_cnt - b0), 32'd0);
    chk("limit_ack_data", dout, 32'h7777_0001);

    b0 = berr_cnt; r0 = req_cnt; s0 = stall_cnt;
    do_access(1, 0, 32'h0000_0200, 32'h0, 0, 32'h0);
    idle(1);
    chk("t4_req_cycles", 32'(req_cnt - r0), 32'd4);
    chk("t4_stall_cycles", 32'(stall_cnt - s0), 32'd5);
    chk("t4_buserr_pulses", 32'(berr_cnt - b0), 32'd1);
    chk("t4_err_data", dout, 32'hDEAD_BEEF);

    cyc(1, 0, 32'h0000_0040, 32'h0, 0, 32'h0, mk(1, 0, 0, 0, 0, '0, '0, m_dout));
    cyc(1, 0, 32'h0000_0040, 32'h0, 0, 32'h0, mk(1, 1, 0, 0, 0, 16'h0010, 32'h0, m_dout));
    @(posedge clk);
    #2;
    rst = 1'b1; rd = 1'b0;
    #1;
    chk("t5_async_req_drop", 32'(bus_req), 32'd0);
    chk("t5_async_stall_drop", 32'(stall), 32'd0);
    m_data = 32'h0; m_dout = 32'h0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, '0, '0, 32'h0));
    cyc(0, 0, 32'h0, 32'h0, 0, 32'h0, mk(0, 0, 0, 0, 0, '0, '0, 32'h0));
    rst = 1'b0;
    do_access(1, 0, 32'h0000_0000, 32'h0, 2, 32'h0F0F_1234);
    idle(1);
    chk("t5_after_reset_data", dout, 32'h0F0F_1234);

`ifdef DMEM_POSTED_WRITE_EN
    s0 = stall_cnt;
    cyc(0, 1, 32'h0000_0044, 32'h1111_2222, 0, 32'h0, mk(0, 0, 0, 0, 0, '0, '0, m_dout));
    for (int j = 1; j <= 3; j++)
      cyc(1, 0, 32'h0000_0048, 32'h0, (j == 3), 32'h0,
          mk(1, 1, 1, 0, 0, 16'h0011, 32'h1111_2222, m_dout));
    do_access(1, 0, 32'h0000_0048, 32'h0, 2, 32'hABCD_0001);
    idle(1);
    chk("t6_stall_cycles", 32'(stall_cnt - s0), 32'd6);
    chk("t6_read_data", dout, 32'hABCD_0001);
`endif

    idle(1);
    @(posedge clk);
    #1;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
